// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display path.
// Holds the conversion FSM state enum, datapath widths and the dabble adjust helper.
package score_disp_pkg;

    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned BIN_W      = 8;
    localparam int unsigned BCD_W      = 12;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned ITER_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [NIB_W-1:0] nib;
        r = b;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            nib = b[i*NIB_W +: NIB_W];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            r[i*NIB_W +: NIB_W] = nib;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble engine: one adjust+shift per clock, BIN_W iterations.
// start loads the operand; done_c is high during the final shift cycle.
module bin2bcd_seq
    import score_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done_c,
    output logic [BCD_W-1:0] bcd
);

    logic [BIN_W-1:0]       sh;
    logic [ITER_W-1:0]      cnt;
    logic                   busy;
    logic [BCD_W+BIN_W-1:0] cat_c;

    // {bcd, bin} adjusted then shifted left by one
    always_comb begin
        cat_c = {dabble_adj(bcd), sh} << 1;
    end

    assign done_c = busy && (cnt == ITER_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sh   <= bin;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            bcd <= cat_c[BCD_W+BIN_W-1:BIN_W];
            sh  <= cat_c[BIN_W-1:0];
            cnt <= cnt + ITER_W'(1);
            if (done_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/score_digit_driver.sv
// Score to 3-digit BCD converter with time-multiplexed digit bus and active-low anodes.
// Optional: define SCORE_LEAD_ZERO_BLANK_EN to blank leading zero digits.
module score_digit_driver
    import score_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             score_vld,
    input  logic [BIN_W-1:0] score,
    output logic             score_rdy,
    output logic [3:0]       dig_val,
    output logic [2:0]       an
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_e           state, state_nxt;
    logic [BCD_W-1:0] disp_bcd, disp_nxt;
    logic [BCD_W-1:0] conv_bcd;
    logic             start_c;
    logic             done_c;

    logic [PRE_W-1:0] pre, pre_nxt;
    logic [1:0]       idx, idx_nxt;
    logic             wrap_c;
    logic [3:0]       dig_nxt;
    logic [2:0]       an_nxt;

    assign start_c = score_vld && score_rdy;

    bin2bcd_seq u_conv (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .bin    (score),
        .done_c (done_c),
        .bcd    (conv_bcd)
    );

    // Conversion FSM; display register only updates in DONE
    always_comb begin
        state_nxt = state;
        disp_nxt  = disp_bcd;
        case (state)
            IDLE: if (start_c) state_nxt = CONV;
            CONV: if (done_c) state_nxt = DONE;
            DONE: begin
                disp_nxt  = conv_bcd;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Scanner; outputs are registered from next-state values so they track without lag
    always_comb begin
        wrap_c  = (pre == PRE_W'(SCAN_DIV - 1));
        pre_nxt = wrap_c ? '0 : pre + PRE_W'(1);
        idx_nxt = idx;
        if (wrap_c) begin
            idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        dig_nxt = '0;
        an_nxt  = 3'b111;
        case (idx_nxt)
            2'd0: begin
                dig_nxt = disp_nxt[3:0];
                an_nxt  = 3'b110;
            end
            2'd1: begin
                dig_nxt = disp_nxt[7:4];
                an_nxt  = 3'b101;
`ifdef SCORE_LEAD_ZERO_BLANK_EN
                if (disp_nxt[11:4] == 8'd0) an_nxt = 3'b111;
`endif
            end
            2'd2: begin
                dig_nxt = disp_nxt[11:8];
                an_nxt  = 3'b011;
`ifdef SCORE_LEAD_ZERO_BLANK_EN
                if (disp_nxt[11:8] == 4'd0) an_nxt = 3'b111;
`endif
            end
            default: begin
                dig_nxt = '0;
                an_nxt  = 3'b111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            score_rdy <= 1'b1;
            disp_bcd  <= '0;
            pre       <= '0;
            idx       <= '0;
            dig_val   <= '0;
            an        <= 3'b110;
        end else begin
            state     <= state_nxt;
            score_rdy <= (state_nxt == IDLE);
            disp_bcd  <= disp_nxt;
            pre       <= pre_nxt;
            idx       <= idx_nxt;
            dig_val   <= dig_nxt;
            an        <= an_nxt;
        end
    end

endmodule

// File: tb/tb_score_digit_driver.sv
// Self-checking bench for score_digit_driver using a cycle-count reference model.
module tb_score_digit_driver;

    localparam int unsigned SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       score_vld;
    logic [7:0] score;
    logic       score_rdy;
    logic [3:0] dig_val;
    logic [2:0] an;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: busy countdown, displayed number, cycles since reset
    int m_busy = 0;
    int m_pend = 0;
    int m_disp = 0;
    int m_scan = 0;

    typedef struct {
        int score;
        int h;
        int t;
        int o;
    } vec_t;

    score_digit_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .score_vld (score_vld),
        .score     (score),
        .score_rdy (score_rdy),
        .dig_val   (dig_val),
        .an        (an)
    );

    always #5 clk = ~clk;

    function automatic int digit_of(input int v, input int i);
        if (i == 0) return v % 10;
        if (i == 1) return (v / 10) % 10;
        return v / 100;
    endfunction

    function automatic int cur_idx();
        return (m_scan / int'(SCAN_DIV)) % 3;
    endfunction

    function automatic int exp_an();
        int i;
        int a;
        i = cur_idx();
        a = 7 & ~(1 << i);
`ifdef SCORE_LEAD_ZERO_BLANK_EN
        if (i == 2 && m_disp < 100) a = 7;
        if (i == 1 && m_disp < 10) a = 7;
`endif
        return a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] s);
        rst = r;
        score_vld = v;
        score = s;
        @(posedge clk);
        if (r) begin
            m_busy = 0;
            m_disp = 0;
            m_scan = 0;
        end else begin
            m_scan++;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_disp = m_pend;
            end else if (v) begin
                m_pend = int'(s);
                m_busy = 9;
            end
        end
        #1;
        chk("rdy", int'(score_rdy), int'(m_busy == 0));
        chk("dig", int'(dig_val), digit_of(m_disp, cur_idx()));
        chk("an", int'(an), exp_an());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'd0);
    endtask

    vec_t tbl[9];

    initial begin
        int busy_len;
        int got;
        tbl[0] = '{0, 0, 0, 0};
        tbl[1] = '{255, 2, 5, 5};
        tbl[2] = '{137, 1, 3, 7};
        tbl[3] = '{42, 0, 4, 2};
        tbl[4] = '{199, 1, 9, 9};
        tbl[5] = '{7, 0, 0, 7};
        tbl[6] = '{40, 0, 4, 0};
        tbl[7] = '{99, 0, 9, 9};
        tbl[8] = '{100, 1, 0, 0};

        rst = 1'b1;
        score_vld = 1'b0;
        score = 8'd0;
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        chk("reset_rdy", int'(score_rdy), 1);
        chk("reset_dig", int'(dig_val), 0);
        chk("reset_an", int'(an), 6);

        // table: convert each score, then scan a full refresh against hand-computed digits
        for (int n = 0; n < 9; n++) begin
            step(1'b0, 1'b1, 8'(tbl[n].score));
            busy_len = 0;
            for (int k = 0; k < 20 && !score_rdy; k++) begin
                busy_len++;
                step(1'b0, 1'b0, 8'd0);
            end
            chk("busy_len", busy_len, 9);
            for (int k = 0; k < 3 * int'(SCAN_DIV); k++) begin
                step(1'b0, 1'b0, 8'd0);
                case (cur_idx())
                    0: got = tbl[n].o;
                    1: got = tbl[n].t;
                    default: got = tbl[n].h;
                endcase
                chk("tbl_digit", int'(dig_val), got);
            end
        end

        // score_vld held through busy window: second score taken only at T+10
        idle(3);
        step(1'b0, 1'b1, 8'd137);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 8'd42);
        chk("held_rdy_before", int'(score_rdy), 1);
        step(1'b0, 1'b1, 8'd42);
        chk("held_accept", int'(score_rdy), 0);
        idle(9);
        chk("held_disp", m_disp, 42);
        idle(12);

        // reset mid-conversion
        step(1'b0, 1'b1, 8'd199);
        idle(3);
        step(1'b1, 1'b0, 8'd0);
        chk("midrst_rdy", int'(score_rdy), 1);
        chk("midrst_dig", int'(dig_val), 0);
        chk("midrst_an", int'(an), 6);
        idle(15);

        // back-to-back at maximum rate
        step(1'b0, 1'b1, 8'd99);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 8'd100);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 8'd0);
            chk("bcd_range", int'(dig_val <= 4'd9), 1);
        end

        // randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        idle(15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
